// File: rtl/sdes_round_engine.sv
// Two-round S-DES Feistel core sitting between IP and FP: fk(Ka), SW, fk(Kb),
// one clocked round per cycle, result held on a valid/ready output port.
module sdes_round_engine #(
  parameter bit KEY_LATCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] input_data,
  input  logic       mode,
  input  logic [7:0] k1,
  input  logic [7:0] k2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] round_data,
  output logic       busy
);

  // Handshake rule for both ports: a transfer happens on a rising clk edge
  // where valid and ready are both 1; valid holds its payload until then.

  typedef enum logic [1:0] {IDLE, RND1, RND2, DONE} state_t;

  // S-box tables, row-major, indexed by {row, col}
  localparam logic [1:0] S0 [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };
  localparam logic [1:0] S1 [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  state_t     state;
  logic [3:0] l_q;
  logic [3:0] r_q;
  logic [7:0] k1_q;
  logic [7:0] k2_q;
  logic       mode_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;

  logic [7:0] k1_use;
  logic [7:0] k2_use;
  logic       use_k1;
  logic [7:0] rnd_key;
  logic [3:0] f_out;

  function automatic logic [3:0] f_func(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] x;
    logic [1:0] s0;
    logic [1:0] s1;
    x  = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
    s0 = S0[{x[7], x[4], x[6], x[5]}];
    s1 = S1[{x[3], x[0], x[2], x[1]}];
    return {s0[0], s1[0], s1[1], s0[1]};
  endfunction

  assign k1_use  = KEY_LATCH ? k1_q : k1;
  assign k2_use  = KEY_LATCH ? k2_q : k2;
  // Encrypt takes K1 in the first round; decrypt reverses the order.
  assign use_k1  = (state == RND1) ^ mode_q;
  assign rnd_key = use_k1 ? k1_use : k2_use;
  assign f_out   = f_func(r_q, rnd_key);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      l_q         <= 4'h0;
      r_q         <= 4'h0;
      k1_q        <= 8'h00;
      k2_q        <= 8'h00;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            l_q        <= input_data[7:4];
            r_q        <= input_data[3:0];
            mode_q     <= mode;
            k1_q       <= k1;
            k2_q       <= k2;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RND1;
          end
        end
        RND1: begin
          l_q   <= r_q;
          r_q   <= l_q ^ f_out;
          state <= RND2;
        end
        RND2: begin
          l_q         <= l_q ^ f_out;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign round_data = {l_q, r_q};

endmodule

// File: tb/tb_sdes_round_engine.sv
// Directed bench for sdes_round_engine: latched-key and live-key instances
// share stimulus; expected bytes come from hand vectors and a textbook model.
module tb_sdes_round_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] input_data;
  logic       mode;
  logic [7:0] k1;
  logic [7:0] k2;
  logic       out_ready;

  logic       in_ready,   in_ready_l;
  logic       out_valid,  out_valid_l;
  logic [7:0] round_data, round_data_l;
  logic       busy,       busy_l;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  sdes_round_engine #(.KEY_LATCH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .input_data(input_data), .mode(mode), .k1(k1), .k2(k2),
    .out_valid(out_valid), .out_ready(out_ready), .round_data(round_data), .busy(busy)
  );

  sdes_round_engine #(.KEY_LATCH(1'b0)) dut_live (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .input_data(input_data), .mode(mode), .k1(k1), .k2(k2),
    .out_valid(out_valid_l), .out_ready(out_ready), .round_data(round_data_l), .busy(busy_l)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish before 300000");
    $fatal(1, "watchdog expired");
  end

  // textbook S-DES F with 1-based bit numbering
  function automatic logic [3:0] f_ref(input logic [3:0] r, input logic [7:0] k);
    int ep_sel [8] = '{4, 1, 2, 3, 2, 3, 4, 1};
    int s0 [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int s1 [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};
    logic [1:4] n;
    logic [1:8] kk;
    logic [1:8] x;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:4] sb;
    n  = r;
    kk = k;
    for (int i = 1; i <= 8; i++) x[i] = n[ep_sel[i-1]] ^ kk[i];
    a  = 2'(s0[{x[1], x[4]}][{x[2], x[3]}]);
    b  = 2'(s1[{x[5], x[8]}][{x[6], x[7]}]);
    sb = {a, b};
    return {sb[2], sb[4], sb[3], sb[1]};
  endfunction

  function automatic logic [7:0] sdes_ref(input logic [7:0] d, input logic m,
                                          input logic [7:0] a, input logic [7:0] b);
    logic [3:0] l, r, t;
    l = d[7:4];
    r = d[3:0];
    t = l ^ f_ref(r, m ? b : a);
    l = r;
    r = t;
    l = l ^ f_ref(r, m ? a : b);
    return {l, r};
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // driver: present one byte at a negedge, leave at the negedge after accept
  task automatic send(input logic [7:0] d, input logic m, input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check1("in_ready_wait", in_ready, 1'b1);
    input_data = d;
    mode       = m;
    k1         = a;
    k2         = b;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  // called one negedge after accept; counts edges until out_valid
  task automatic wait_out(output int edges);
    edges = 0;
    while (!out_valid && edges < 8) begin
      @(negedge clk);
      edges++;
    end
    check1("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] d, input logic m,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    int n;
    send(d, m, a, b);
    exp_q.push_back(exp);
    wait_out(n);
    check8({tag, "_latency"}, 8'(n), 8'd2);
    check8(tag, round_data, exp_q.pop_front());
    @(negedge clk);
    check1({tag, "_out_valid_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    int n;
    logic [7:0] d, a, b, c;

    // reset with in_valid asserted
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    input_data = 8'h5A;
    mode       = 1'b0;
    k1         = 8'h00;
    k2         = 8'h00;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check8("rst_round_data", round_data, 8'h00);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check1("rel_in_ready", in_ready, 1'b1);
    check1("rel_in_ready_live", in_ready_l, 1'b1);
    check1("rel_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check1("rel_busy", busy, 1'b0);
    check1("rel_no_output", out_valid, 1'b0);

    // zero vector with intermediate after RND1
    send(8'h00, 1'b0, 8'h00, 8'h00);
    check1("zero_busy_rnd1", busy, 1'b1);
    check1("zero_in_ready_rnd1", in_ready, 1'b0);
    @(negedge clk);
    check8("zero_after_rnd1", round_data, 8'h08);
    check1("zero_not_yet_valid", out_valid, 1'b0);
    @(negedge clk);
    check1("zero_valid_2_edges", out_valid, 1'b1);
    check8("zero_result", round_data, 8'hB8);
    @(negedge clk);
    check1("zero_handshake_drop", out_valid, 1'b0);
    check1("zero_back_idle", in_ready, 1'b1);

    // directed vectors
    run_txn("dec_b8", 8'hB8, 1'b1, 8'h00, 8'h00, 8'h00);
    run_txn("enc_k2_ff", 8'h00, 1'b0, 8'h00, 8'hFF, 8'h88);
    run_txn("dec_k2_ff", 8'h00, 1'b1, 8'h00, 8'hFF, 8'h87);
    run_txn("dec_88", 8'h88, 1'b1, 8'h00, 8'hFF, 8'h00);
    run_txn("enc_textbook", 8'h5D, 1'b0, 8'hA4, 8'h43, 8'h2A);
    run_txn("dec_textbook", 8'h2A, 1'b1, 8'hA4, 8'h43, 8'h5D);

    // backpressure: hold DONE for 10 cycles while poking in_valid
    out_ready = 1'b0;
    send(8'h5D, 1'b0, 8'hA4, 8'h43);
    wait_out(n);
    check8("bp_result", round_data, 8'h2A);
    for (int i = 0; i < 10; i++) begin
      in_valid   = (i % 3 == 0);
      input_data = 8'($urandom_range(0, 255));
      mode       = 1'($urandom_range(0, 1));
      k1         = 8'($urandom_range(0, 255));
      @(negedge clk);
      check1("bp_out_valid", out_valid, 1'b1);
      check8("bp_round_data", round_data, 8'h2A);
      check1("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check1("bp_release_drop", out_valid, 1'b0);
    check1("bp_release_idle", in_ready, 1'b1);
    check1("bp_release_busy", busy, 1'b0);
    @(negedge clk);
    check1("bp_single_output", out_valid, 1'b0);
    check1("bp_no_accept", busy, 1'b0);

    // keys change during RND1
    send(8'h00, 1'b0, 8'h00, 8'h00);
    k1 = 8'hFF;
    k2 = 8'hFF;
    wait_out(n);
    check8("keylatch_rnd1", round_data, 8'hB8);
    check1("keylive_rnd1_valid", out_valid_l, 1'b1);
    check8("keylive_rnd1", round_data_l, 8'hB7);
    @(negedge clk);

    // k2 changes between rounds
    send(8'h00, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    k2 = 8'hFF;
    @(negedge clk);
    check1("keylatch_rnd2_valid", out_valid, 1'b1);
    check8("keylatch_rnd2", round_data, 8'hB8);
    check8("keylive_rnd2", round_data_l, 8'h88);
    @(negedge clk);

    // abort in RND2
    send(8'h5D, 1'b0, 8'hA4, 8'h43);
    @(negedge clk);
    check1("abort_in_rnd2", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("abort_out_valid", out_valid, 1'b0);
    check8("abort_round_data", round_data, 8'h00);
    check1("abort_in_ready", in_ready, 1'b0);
    check1("abort_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("abort_rel_in_ready", in_ready, 1'b1);
    check1("abort_no_output", out_valid, 1'b0);
    @(negedge clk);
    check1("abort_still_no_output", out_valid, 1'b0);
    run_txn("abort_after", 8'h2A, 1'b1, 8'hA4, 8'h43, 8'h5D);

    // random round trips against the model
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom_range(0, 255));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = sdes_ref(d, 1'b0, a, b);
      run_txn("rand_enc", d, 1'b0, a, b, c);
      run_txn("rand_dec", c, 1'b1, a, b, d);
    end

    check8("exp_q_drained", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sdes_round_engine.md
Name: sdes_round_engine

Overview:
- Sequential S-DES Feistel core between the initial-permutation stage (IP, type_1=0) and the final-permutation stage (FP, type_1=1) of the 8-bit S-DES datapath.
- Accepts one IP-permuted byte per transaction and applies fk(K_a), SW, fk(K_b) over two clocked rounds.
- Presents the pre-FP byte on a valid/ready output port.
- Encrypt uses K1 then K2; decrypt uses K2 then K1.

Parameters:
- KEY_LATCH, 1: 1 = k1/k2 are captured at the input handshake and the captured values are used for the whole transaction. 0 = live k1/k2 are used in each round.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input_data and mode are valid
- in_ready  output  1  block can accept a transaction
- input_data  input  8  IP-permuted byte; bit 7 = S-DES bit 1
- mode  input  1  0 = encrypt, 1 = decrypt
- k1  input  8  subkey K1
- k2  input  8  subkey K2
- out_valid  output  1  round_data holds a result
- out_ready  input  1  downstream (FP stage) accepts the result
- round_data  output  8  pre-FP byte {L,R}
- busy  output  1  high in RND1, RND2 and DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; L, R, latched keys and mode = 0.
  - round_data=0, out_valid=0, in_ready=0 during reset; in_ready=1 from the first clock edge after release; busy=0.
- Asserting rst_n low mid-transaction aborts it immediately. No output is produced for the aborted transaction.
- FSM states: IDLE, RND1, RND2, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready: L=input_data[7:4], R=input_data[3:0]; latch mode (and keys if KEY_LATCH=1); go to RND1.
  - RND1: subkey Ka = mode?K2:K1. Update {L,R} <= {R, L^F(R,Ka)} (fk then SW). Go to RND2.
  - RND2: subkey Kb = mode?K1:K2. Update {L,R} <= {L^F(R,Kb), R} (fk, no swap). Go to DONE.
  - DONE: out_valid=1; round_data={L,R} held stable. On out_ready go to IDLE; out_valid drops on the next edge.
- in_ready is 0 outside IDLE. in_valid in those states is ignored, and input_data, mode and keys may change freely.
- Latency: input handshake at edge N, out_valid high after edge N+2. If out_ready is held at 1, the output handshake happens at edge N+3 and the next input is accepted at N+4 at the earliest (throughput one byte per 4 cycles).
- in_ready is registered from state only; there is no combinational path from out_ready to in_ready.
- F(R,K): R bits r1..r4 = R[3],R[2],R[1],R[0].
  - E/P = {R[0],R[3],R[2],R[1],R[2],R[1],R[0],R[3]}; x = E/P ^ K.
  - S0 operates on x[7:4], S1 on x[3:0]. For each nibble b1..b4 (b1 = MSB): row = {b1,b4}, col = {b2,b3}.
  - S0 rows: 1 0 3 2 / 3 2 1 0 / 0 2 1 3 / 3 1 3 2.
  - S1 rows: 0 1 2 3 / 2 0 1 3 / 3 0 1 0 / 2 1 0 3.
  - Each S-box gives 2 bits s[1:0]. P4 = {s0[0], s1[0], s1[1], s0[1]}.
- All arithmetic is bitwise XOR on fixed widths; there is no carry or overflow.
- KEY_LATCH=0: keys are sampled in RND1 and RND2 respectively. A key change between rounds is legal and takes effect in the next round.

Test Plan:
- Reset: rst_n=0 with in_valid=1 -> out_valid=0, round_data=8'h00, in_ready=0, busy=0. After release, in_ready=1 from the first edge, and there is no spurious output.
- Encrypt zero vector: input_data=8'h00, k1=k2=8'h00, mode=0, out_ready=1 -> out_valid rises exactly 2 edges after accept; round_data=8'hB8. Intermediate after RND1: {L,R}=8'h08.
- Round trip: feed 8'hB8, k1=k2=8'h00, mode=1 -> round_data=8'h00. Repeat with 200 random data/k1/k2: encrypt result fed back with mode=1 returns the original input_data.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, round_data stable, in_ready=0, and in_valid pulses with new data are ignored. Release -> exactly one output handshake, then IDLE.
- Key latching: KEY_LATCH=1, change k1/k2 during RND1 -> result equals that of the keys present at accept. With KEY_LATCH=0, the result reflects the new keys.
- Abort: drop rst_n during RND2 -> outputs reset immediately. A new transaction after release completes with the correct result, and no output is produced for the aborted one.
